// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer: CTRL (+0), PRESET (+4), COUNT (+8, read-only).
// Optional prescaler enabled by defining TC_PRESCALE_EN.
module timer_counter #(
    parameter logic [31:0] BASE     = 32'h0000_7f00,
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic        hit;
    logic [1:0]  sel;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        auto_reload;
    logic        tick;
    logic        unused;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("timer_counter: PRESCALE must be >= 1");
    end

`ifdef TC_PRESCALE_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pcnt;
    assign tick = (pcnt == PW'(PRESCALE - 1));
`else
    assign tick = 1'b1;
`endif

    assign hit         = (addr[31:4] == BASE[31:4]) && (addr[3:2] != 2'd3);
    assign sel         = addr[3:2];
    assign ctrl_wr     = hit && (|byteen) && (sel == 2'd0);
    assign preset_wr   = hit && (|byteen) && (sel == 2'd1);
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign irq         = irq_flag & ctrl[3];
    assign unused      = &{1'b0, addr[1:0]};

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (sel)
                2'd0:    rdata = {28'b0, ctrl};
                2'd1:    rdata = preset;
                2'd2:    rdata = count;
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
`ifdef TC_PRESCALE_EN
            pcnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (ctrl[0]) state <= LOAD;
                LOAD: begin
                    count    <= preset;
                    irq_flag <= 1'b0;
`ifdef TC_PRESCALE_EN
                    pcnt     <= '0;
`endif
                    state    <= CNT;
                end
                CNT: begin
                    if (!ctrl[0]) begin
                        state <= IDLE;
                    end else begin
`ifdef TC_PRESCALE_EN
                        pcnt <= tick ? '0 : pcnt + 1'b1;
`endif
                        if (tick) begin
                            if (count > 32'd1) begin
                                count <= count - 32'd1;
                            end else begin
                                count    <= '0;
                                irq_flag <= 1'b1;
                                state    <= INT;
                            end
                        end
                    end
                end
                INT: begin
                    if (auto_reload) begin
                        irq_flag <= 1'b0;
                        state    <= LOAD;
                    end else begin
                        // A coincident CPU CTRL write keeps its EN bit
                        if (!ctrl_wr) ctrl[0] <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // CPU writes come last so they take priority over FSM updates
            if (ctrl_wr) begin
                irq_flag <= 1'b0;
                if (byteen[0]) ctrl <= wdata[3:0];
            end
            for (int unsigned i = 0; i < 4; i++) begin
                if (preset_wr && byteen[i]) preset[8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: stimulus queues expected rdata/irq per cycle,
// a negedge monitor pops and compares them.
module tb_timer_counter;

    localparam logic [31:0] BASE = 32'h0000_7f00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    timer_counter #(.BASE(BASE), .PRESCALE(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .byteen(byteen),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned at;
        bit          is_irq;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] act;

    task automatic push(input int unsigned at, input bit is_irq, input logic [31:0] val,
                        input string name);
        exp_t e;
        e.at = at; e.is_irq = is_irq; e.val = val; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic exp_rd(input int unsigned at, input logic [31:0] val, input string name);
        push(at, 1'b0, val, name);
    endtask

    task automatic exp_irq(input int unsigned at, input logic val, input string name);
        push(at, 1'b1, {31'b0, val}, name);
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        addr = a; byteen = be; wdata = d;
        step(1);
        byteen = '0;
    endtask

    always @(negedge clk) begin
        for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
            if (exp_q[i].at <= cyc) begin
                checks++;
                act = exp_q[i].is_irq ? {31'b0, irq} : rdata;
                if (exp_q[i].at != cyc) begin
                    errors++;
                    $display("FAIL %s: check for cycle %0d not sampled (now %0d)",
                             exp_q[i].name, exp_q[i].at, cyc);
                end else if (act !== exp_q[i].val) begin
                    errors++;
                    $display("FAIL %s @cycle %0d: got %h expected %h",
                             exp_q[i].name, cyc, act, exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
    end

    int unsigned e0, e1;

    initial begin
        reset = 1'b0; addr = '0; byteen = '0; wdata = '0;
        step(2);
        reset = 1'b1;

        // reset after activity
        wr(BASE + 4, 4'hf, 32'h1234_5678);
        wr(BASE, 4'hf, 32'hffff_fff9);
        step(3);
        reset = 1'b0; step(1); reset = 1'b1;
        addr = BASE;     exp_rd(cyc, 32'h0, "rst_ctrl"); exp_irq(cyc, 1'b0, "rst_irq");
        step(1);
        addr = BASE + 4; exp_rd(cyc, 32'h0, "rst_preset");
        step(1);
        addr = BASE + 8; exp_rd(cyc, 32'h0, "rst_count");
        exp_rd(cyc + 2, 32'h0, "rst_count_idle");
        step(3);

        // one-shot, PRESET=5
        wr(BASE + 4, 4'hf, 32'd5);
        wr(BASE, 4'b0001, 32'h9);
        e0 = cyc; addr = BASE + 8;
        for (int n = 2; n <= 7; n++) exp_rd(e0 + n, 32'(7 - n), "oneshot_count");
        exp_irq(e0 + 6, 1'b0, "oneshot_irq_early");
        for (int n = 7; n <= 9; n++) exp_irq(e0 + n, 1'b1, "oneshot_irq_hold");
        step(9);
        addr = BASE; exp_rd(cyc, 32'h8, "oneshot_ctrl_en_cleared");
        step(1);
        wr(BASE, 4'b0001, 32'h0);
        exp_irq(cyc, 1'b0, "irq_clear_on_ctrl_write");
        exp_rd(cyc, 32'h0, "ctrl_zero");
        step(1);

        // auto-reload, PRESET=3
        wr(BASE + 4, 4'hf, 32'd3);
        wr(BASE, 4'b0001, 32'hb);
        e0 = cyc; addr = BASE + 8;
        for (int k = 0; k < 3; k++) begin
            exp_irq(e0 + 4 + 5*k, 1'b0, "reload_irq_before");
            exp_irq(e0 + 5 + 5*k, 1'b1, "reload_irq_pulse");
            exp_irq(e0 + 6 + 5*k, 1'b0, "reload_irq_after");
        end
        exp_rd(e0 + 2, 32'd3, "reload_count_first");
        exp_rd(e0 + 7, 32'd3, "reload_count_second");
        step(16);
        wr(BASE, 4'b0001, 32'h0);
        step(4);
        addr = BASE + 8;
        exp_rd(cyc, 32'd3, "stopped_count_hold");
        exp_irq(cyc, 1'b0, "stopped_irq");
        step(1);

        // register access corner cases
        wr(BASE + 8, 4'hf, 32'hdead_beef);
        addr = BASE + 8; exp_rd(cyc, 32'd3, "count_read_only");
        step(1);
        wr(BASE + 4, 4'hf, 32'h0);
        wr(BASE + 5, 4'b0010, 32'habab_abab);
        addr = BASE + 4; exp_rd(cyc, 32'h0000_ab00, "preset_byte_lane");
        step(1);
        wr(BASE + 6, 4'b1100, 32'h1234_1234);
        addr = BASE + 4; exp_rd(cyc, 32'h1234_ab00, "preset_half_lane");
        step(1);
        addr = BASE + 12; exp_rd(cyc, 32'h0, "read_hole");
        step(1);
        addr = BASE + 16; exp_rd(cyc, 32'h0, "read_outside");
        step(1);

        // stop mid-count, then restart
        wr(BASE + 4, 4'hf, 32'd10);
        wr(BASE, 4'b0001, 32'h9);
        e0 = cyc; addr = BASE + 8;
        exp_rd(e0 + 2, 32'd10, "pause_count_load");
        exp_rd(e0 + 4, 32'd8, "pause_count_run");
        step(5);
        wr(BASE, 4'b0001, 32'h0);
        addr = BASE + 8;
        for (int j = 0; j < 4; j++) exp_rd(cyc + j, 32'd6, "pause_count_hold");
        step(4);
        wr(BASE, 4'b0001, 32'h9);
        e1 = cyc; addr = BASE + 8;
        exp_rd(e1 + 2, 32'd10, "restart_reload");
        exp_irq(e1 + 11, 1'b0, "restart_irq_early");
        exp_irq(e1 + 12, 1'b1, "restart_irq");
        exp_rd(e1 + 12, 32'h0, "restart_count_zero");
        step(12);
        reset = 1'b0; step(1); reset = 1'b1;
        exp_irq(cyc, 1'b0, "irq_after_reset");
        exp_rd(cyc, 32'h0, "count_after_reset");
        step(2);

`ifdef TC_PRESCALE_EN
        // prescaled count, PRESCALE=4, PRESET=2
        wr(BASE + 4, 4'hf, 32'd2);
        wr(BASE, 4'b0001, 32'h9);
        e0 = cyc; addr = BASE + 8;
        exp_rd(e0 + 5, 32'd2, "pre_count_hold");
        exp_rd(e0 + 6, 32'd1, "pre_count_tick");
        exp_irq(e0 + 9, 1'b0, "pre_irq_early");
        exp_irq(e0 + 10, 1'b1, "pre_irq");
        step(11);
        reset = 1'b0; step(1); reset = 1'b1;
        wr(BASE + 4, 4'hf, 32'd2);
        wr(BASE, 4'b0001, 32'h9);
        addr = BASE + 8;
        step(5);
        reset = 1'b0; step(1); reset = 1'b1;
        for (int j = 0; j < 7; j++) begin
            exp_irq(cyc + j, 1'b0, "pre_reset_irq");
            exp_rd(cyc + j, 32'h0, "pre_reset_count");
        end
        step(8);
`endif

        step(2);
        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: check for cycle %0d never sampled", exp_q[0].name, exp_q[0].at);
            exp_q.delete(0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
